// File: rtl/instruction_loader.sv
// instruction_loader: framed byte-stream loader for the 32-word instruction memory.
// Inputs: clk, reset (sync, active-high), start, s_valid, s_data[7:0].
// Outputs: s_ready, WE, WA[AW-1:0], WD[31:0], busy, done, error, words[AW:0].
// Option: INSTRUCTION_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module instruction_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          WE,
    output logic [AW-1:0] WA,
    output logic [31:0]   WD,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW:0]   words
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        CHECK = 3'd3,
`endif
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   n_q, n_d;
    logic [1:0]    idx_q, idx_d;
    logic [23:0]   buf_q, buf_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [31:0]   wd_q, wd_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [AW:0]   words_q, words_d;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif
    logic          acc;
    logic          bad_n;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        done_d  = done_q;
        error_d = error_q;
        words_d = words_q;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        s_ready = 1'b0;
        unique case (state_q)
            COUNT:   s_ready = 1'b1;
            DATA:    s_ready = 1'b1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            CHECK:   s_ready = 1'b1;
`endif
            default: s_ready = 1'b0;
        endcase
        acc   = s_valid && s_ready;
        bad_n = (s_data == 8'd0) || (s_data > 8'(DEPTH));

        unique case (state_q)
            COUNT: begin
                if (acc) begin
                    if (bad_n) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = DATA;
                        n_d     = s_data[AW:0];
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        csum_d  = csum_q ^ s_data;
`endif
                    end
                end
            end
            DATA: begin
                if (acc) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ s_data;
`endif
                    idx_d = idx_q + 2'd1;
                    unique case (idx_q)
                        2'd0: buf_d[7:0]   = s_data;
                        2'd1: buf_d[15:8]  = s_data;
                        2'd2: buf_d[23:16] = s_data;
                        default: begin
                            // words_q is the index of the word being built
                            we_d    = 1'b1;
                            wa_d    = words_q[AW-1:0];
                            wd_d    = {s_data, buf_q};
                            words_d = words_q + 1'b1;
                            if (words_q + 1'b1 == n_q) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                                state_d = CHECK;
`else
                                state_d = DONE;
                                done_d  = 1'b1;
`endif
                            end
                        end
                    endcase
                end
            end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            CHECK: begin
                if (acc) begin
                    if (s_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: begin
                if (start) begin
                    state_d = COUNT;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    words_d = '0;
                    idx_d   = 2'd0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            idx_q   <= 2'd0;
            buf_q   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            words_q <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
            error_q <= error_d;
            words_q <= words_d;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign busy  = s_ready;
    assign WE    = we_q;
    assign WA    = wa_q;
    assign WD    = wd_q;
    assign done  = done_q;
    assign error = error_q;
    assign words = words_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed self-checking bench for instruction_loader.
// Drives on negedge, samples on negedge; a monitor logs every write.
module tb_instruction_loader;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'd0;
    logic          s_ready;
    logic          WE;
    logic [AW-1:0] WA;
    logic [31:0]   WD;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words;

    int checks = 0;
    int failures = 0;

    int          nw = 0;
    int          cyc = 0;
    logic [AW-1:0] wr_addr [0:255];
    logic [31:0] wr_data [0:255];
    int          wr_cyc  [0:255];

    instruction_loader #(.DEPTH(32), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .WE(WE), .WA(WA), .WD(WD), .busy(busy),
        .done(done), .error(error), .words(words)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (WE === 1'b1 && nw < 256) begin
            wr_addr[nw] <= WA;
            wr_data[nw] <= WD;
            wr_cyc[nw]  <= cyc;
            nw <= nw + 1;
        end
    end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    function automatic logic [7:0] fold(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction
`endif

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        s_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        s_valid = 1'b1;
        s_data = b;
        t = 0;
        while (s_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (s_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout s_ready=%b required 1", s_ready);
        end
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({s_ready, WE, busy, done, error, WA, WD, words} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required 0",
                     {s_ready, WE, busy, done, error, WA, WD, words});
        end
    endtask

    task automatic test_single();
        int base;
        base = nw;
        do_reset();
        do_start();
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_ready s_ready=%b busy=%b required 1 1",
                     s_ready, busy);
        end
        send_byte(8'h01);
        send_word(32'h02328020);
        @(negedge clk);
        s_valid = 1'b0;
`ifndef INSTRUCTION_LOADER_CHECKSUM_EN
        checks++;
        if (WE !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL last_we_done we=%b done=%b busy=%b required 1 1 0",
                     WE, done, busy);
        end
`else
        checks++;
        if (WE !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL last_we_check we=%b busy=%b required 1 1",
                     WE, busy);
        end
        send_byte(8'h01 ^ fold(32'h02328020));
`endif
        idle(3);
        checks++;
        if (nw - base !== 1 || wr_addr[base] !== 5'd0
            || wr_data[base] !== 32'h02328020) begin
            failures++;
            $display("FAIL single_write n=%0d wa=%h wd=%h required 1 00 02328020",
                     nw - base, wr_addr[base], wr_data[base]);
        end
        checks++;
        if (words !== 6'd1 || done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL single_status words=%0d done=%b error=%b required 1 1 0",
                     words, done, error);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [7:0] cs;
        base = nw;
        cs = 8'd32;
        do_start();
        send_byte(8'd32);
        for (int k = 0; k < 32; k++) begin
            send_word(k * 32'h01010101);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            cs = cs ^ fold(k * 32'h01010101);
`endif
        end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        send_byte(cs);
`endif
        idle(3);
        checks++;
        if (nw - base !== 32) begin
            failures++;
            $display("FAIL b2b_count got=%0d required 32", nw - base);
        end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (wr_addr[base+k] !== 5'(k)
                || wr_data[base+k] !== k * 32'h01010101) begin
                failures++;
                $display("FAIL b2b_word%0d wa=%h wd=%h required %h %h", k,
                         wr_addr[base+k], wr_data[base+k], 5'(k),
                         k * 32'h01010101);
            end
            if (k > 0) begin
                checks++;
                if (wr_cyc[base+k] - wr_cyc[base+k-1] !== 4) begin
                    failures++;
                    $display("FAIL b2b_spacing%0d got=%0d required 4", k,
                             wr_cyc[base+k] - wr_cyc[base+k-1]);
                end
            end
        end
        checks++;
        if (words !== 6'd32 || done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL b2b_status words=%0d done=%b error=%b required 32 1 0",
                     words, done, error);
        end
    endtask

    task automatic test_bad_count(input logic [7:0] n);
        int base;
        base = nw;
        do_reset();
        do_start();
        send_byte(n);
        idle(1);
        checks++;
        if (error !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0
            || done !== 1'b0) begin
            failures++;
            $display("FAIL bad_count_%h error=%b s_ready=%b busy=%b done=%b required 1 0 0 0",
                     n, error, s_ready, busy, done);
        end
        idle(2);
        checks++;
        if (nw - base !== 0) begin
            failures++;
            $display("FAIL bad_count_%h_we writes=%0d required 0",
                     n, nw - base);
        end
    endtask

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        int base;
        base = nw;
        do_reset();
        do_start();
        send_byte(8'h01);
        send_word(32'h02328020);
        send_byte(~(8'h01 ^ fold(32'h02328020)));
        idle(1);
        checks++;
        if (nw - base !== 1 || error !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL bad_checksum writes=%0d error=%b done=%b required 1 1 0",
                     nw - base, error, done);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int base;
        base = nw;
        do_reset();
        do_start();
        send_byte(8'd5);
        for (int k = 0; k < 3; k++) send_word(32'h10000000 + k);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        s_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({s_ready, WE, busy, done, error, WA, WD, words} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%h required 0",
                     {s_ready, WE, busy, done, error, WA, WD, words});
        end
        idle(4);
        checks++;
        if (nw - base !== 3) begin
            failures++;
            $display("FAIL reset_mid_writes got=%0d required 3", nw - base);
        end
        base = nw;
        do_start();
        send_byte(8'h01);
        send_word(32'hCAFEF00D);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        send_byte(8'h01 ^ fold(32'hCAFEF00D));
`endif
        idle(3);
        checks++;
        if (nw - base !== 1 || wr_addr[base] !== 5'd0
            || wr_data[base] !== 32'hCAFEF00D || done !== 1'b1
            || words !== 6'd1) begin
            failures++;
            $display("FAIL reset_mid_reload n=%0d wa=%h wd=%h done=%b words=%0d required 1 00 cafef00d 1 1",
                     nw - base, wr_addr[base], wr_data[base], done, words);
        end
    endtask

    task automatic test_stall_start();
        int base;
        base = nw;
        do_reset();
        do_start();
        send_byte(8'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(4);
        checks++;
        if (nw - base !== 0 || busy !== 1'b1 || words !== 6'd0
            || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold writes=%0d busy=%b words=%0d s_ready=%b required 0 1 0 1",
                     nw - base, busy, words, s_ready);
        end
        send_byte(8'h33);
        send_byte(8'h44);
        send_word(32'hDDCCBBAA);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        send_byte(8'd2 ^ fold(32'h44332211) ^ fold(32'hDDCCBBAA));
`endif
        idle(3);
        checks++;
        if (nw - base !== 2 || wr_data[base] !== 32'h44332211
            || wr_addr[base+1] !== 5'd1
            || wr_data[base+1] !== 32'hDDCCBBAA) begin
            failures++;
            $display("FAIL stall_words n=%0d wd0=%h wa1=%h wd1=%h required 2 44332211 01 ddccbbaa",
                     nw - base, wr_data[base], wr_addr[base+1],
                     wr_data[base+1]);
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || words !== 6'd2) begin
            failures++;
            $display("FAIL stall_status done=%b error=%b words=%0d required 1 0 2",
                     done, error, words);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_count(8'h00);
        test_bad_count(8'h21);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_reset_mid();
        test_stall_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
